int_ctrl: RTL

//  Interrupt controller upstream of the CPU core: latches up to N_SRC peripheral

---
 rtl/int_ctrl_pkg.sv | 32 +++
 rtl/int_ctrl_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the register window offsets, the GIE bit index, the FSM state
// encodings and the vector address helper.
package int_ctrl_pkg;

   // Register offsets relative to the window base address
   localparam logic [7:0] OFF_CTRL  = 8'd0;
   localparam logic [7:0] OFF_MASK  = 8'd1;
   localparam logic [7:0] OFF_PEND  = 8'd2;
   localparam logic [7:0] OFF_VBASE = 8'd3;
   localparam logic [7:0] OFF_SWI   = 8'd4;

   // Global interrupt enable position inside CTRL and int_en
   localparam int GIE_BIT = 0;

   // Request handshake states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_e;

   // ISR entry address: vector base plus the scaled source id, 8-bit wrap
   function automatic logic [7:0] calc_vector(input logic [7:0] vbase,
                                              input logic [2:0] id,
                                              input int         shift);
      logic [7:0] id_ext;
      id_ext = {5'b00000, id};
      return vbase + (id_ext << shift);
   endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder for the interrupt controller.
// Lowest set index wins; purely combinational.
module int_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [2:0]   id
);

   // Scan from the top down so the lowest active index is written last
   always_comb begin
      valid = |req;
      id    = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = 3'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller sitting in front of the CPU core.
// Latches rising edges on the peripheral lines, masks and prioritises them,
// and hands one request at a time to the core until it executes ret.
// Optional feature: define INT_CTRL_SWI_EN to enable the software
// interrupt register (+4, write-1-to-set on PEND).
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int         N_SRC     = 8,
   parameter logic [7:0] BASE_ADDR = 8'hF0,
   parameter int         VEC_SHIFT = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [7:0]       mem_addr,
   input  logic [7:0]       mem_w_data,
   input  logic             mem_w_en,
   output logic [7:0]       mem_r_data,
   input  logic             ret,
   output logic             int_req,
   output logic [7:0]       int_en,
   output logic [7:0]       int_vec
);

   logic             gie;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] irq_prev;
   logic [7:0]       vbase;

   int_state_e       state;
   int_state_e       state_next;

   logic [7:0]       reg_off;
   logic             in_win;
   logic             wr_ctrl;
   logic             wr_mask;
   logic             wr_pend;
   logic             wr_vbase;

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] swi_set;
   logic [N_SRC-1:0] w1c_clr;
   logic [N_SRC-1:0] auto_clr;
   logic [N_SRC-1:0] pend_next;
   logic [N_SRC-1:0] active;

   logic             win_valid;
   logic [2:0]       win_id;
   logic             take;

   assign reg_off  = mem_addr - BASE_ADDR;
   assign in_win   = (reg_off <= OFF_SWI);
   assign wr_ctrl  = mem_w_en && (reg_off == OFF_CTRL);
   assign wr_mask  = mem_w_en && (reg_off == OFF_MASK);
   assign wr_pend  = mem_w_en && (reg_off == OFF_PEND);
   assign wr_vbase = mem_w_en && (reg_off == OFF_VBASE);

   assign rise     = irq_src & ~irq_prev;
   assign w1c_clr  = wr_pend ? mem_w_data[N_SRC-1:0] : '0;
   assign active   = pend & mask;
   assign int_en   = {7'b0000000, gie};

`ifdef INT_CTRL_SWI_EN
   logic wr_swi;
   assign wr_swi  = mem_w_en && (reg_off == OFF_SWI);
   assign swi_set = wr_swi ? mem_w_data[N_SRC-1:0] : '0;
`else
   assign swi_set = '0;
`endif

   int_prio_enc #(
      .N (N_SRC)
   ) u_prio (
      .req   (active),
      .valid (win_valid),
      .id    (win_id)
   );

   // Clear the winning pending bit on the cycle its request is issued
   always_comb begin
      auto_clr = '0;
      if (take) begin
         auto_clr[win_id] = 1'b1;
      end
   end

   // Every set source beats every clear source on the same bit
   always_comb begin
      pend_next = (pend & ~w1c_clr & ~auto_clr) | rise | swi_set;
   end

   // Register window readback, zero outside the window
   always_comb begin
      mem_r_data = 8'h00;
      if (in_win) begin
         case (reg_off)
            OFF_CTRL:  mem_r_data[GIE_BIT] = gie;
            OFF_MASK:  mem_r_data = 8'(mask);
            OFF_PEND:  mem_r_data = 8'(pend);
            OFF_VBASE: mem_r_data = vbase;
            default:   mem_r_data = 8'h00;
         endcase
      end
   end

   // Programmable registers, pending latch and edge-detect history
   always_ff @(posedge clock) begin
      if (reset) begin
         gie      <= 1'b0;
         mask     <= '0;
         pend     <= '0;
         vbase    <= 8'h00;
         irq_prev <= '0;
      end else begin
         irq_prev <= irq_src;
         pend     <= pend_next;
         if (wr_ctrl) begin
            gie <= mem_w_data[GIE_BIT];
         end
         if (wr_mask) begin
            mask <= mem_w_data[N_SRC-1:0];
         end
         if (wr_vbase) begin
            vbase <= mem_w_data;
         end
      end
   end

   // Request FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: one request in flight at a time, released by ret
   always_comb begin
      state_next = state;
      take       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (gie && win_valid) begin
               state_next = ST_REQ;
               take       = 1'b1;
            end
         end
         ST_REQ: begin
            state_next = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (ret) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Registered request pulse and vector, latched as the request is taken
   always_ff @(posedge clock) begin
      if (reset) begin
         int_req <= 1'b0;
         int_vec <= 8'h00;
      end else begin
         int_req <= take;
         if (take) begin
            int_vec <= calc_vector(vbase, win_id, VEC_SHIFT);
         end
      end
   end

endmodule
